// File: rtl/aes_pkg.sv
// Shared AES constants and types for the key-expansion controller.
package aes_pkg;

    typedef logic [31:0]  word_t;
    typedef logic [127:0] key128_t;

    typedef enum logic {
        KS_IDLE,
        KS_EMIT
    } ks_state_t;

    localparam logic [3:0] AES_ROUNDS = 4'd10;

    localparam logic [7:0] RCON [0:9] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

endpackage

// File: rtl/aes_ks_gword.sv
// Key-schedule g-function: SubWord(RotWord(w)) ^ {Rcon[rnd-1], 24'h0}, rnd in 1..10.
module aes_ks_gword
    import aes_pkg::*;
(
    input  word_t      w,
    input  logic [3:0] rnd,
    output word_t      g
);

    word_t      rot;
    word_t      sub;
    logic [7:0] rc;
    logic [3:0] rcon_idx;

    always_comb begin
        rot      = {w[23:0], w[31:24]};
        sub      = {SBOX[rot[31:24]], SBOX[rot[23:16]], SBOX[rot[15:8]], SBOX[rot[7:0]]};
        rcon_idx = rnd - 4'd1;
        rc       = 8'h00;
        // Out-of-range round indices contribute no round constant.
        if (rnd >= 4'd1 && rnd <= AES_ROUNDS) begin
            rc = RCON[rcon_idx];
        end
        g = sub ^ {rc, 24'h000000};
    end

endmodule

// File: rtl/aes_key_sched.sv
// Iterative AES-128 key expansion, one round key per transfer on a valid/ready stream.
// Optional round-key store with registered read port: AES_KS_RK_STORE_EN.
//
// state   | meaning
// KS_IDLE | waiting for start; rk_valid low
// KS_EMIT | presenting rk_round/rk_data until the consumer takes it
module aes_key_sched
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key,
    output logic         busy,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk_data,
    output logic [3:0]   rk_round,
`ifdef AES_KS_RK_STORE_EN
    input  logic [3:0]   rd_idx,
    output logic [127:0] rd_data,
    output logic         keys_valid,
`endif
    output logic         done
);

    ks_state_t  state_q, state_d;
    key128_t    cur_key, key_d, key_exp;
    logic [3:0] round_q, round_d;
    word_t      g;

    aes_ks_gword u_gword (
        .w   (cur_key[31:0]),
        .rnd (round_q + 4'd1),
        .g   (g)
    );

    always_comb begin
        key_exp[127:96] = cur_key[127:96] ^ g;
        key_exp[95:64]  = cur_key[95:64]  ^ key_exp[127:96];
        key_exp[63:32]  = cur_key[63:32]  ^ key_exp[95:64];
        key_exp[31:0]   = cur_key[31:0]   ^ key_exp[63:32];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= KS_IDLE;
            cur_key <= '0;
            round_q <= '0;
        end else begin
            state_q <= state_d;
            cur_key <= key_d;
            round_q <= round_d;
        end
    end

    always_comb begin
        state_d = state_q;
        key_d   = cur_key;
        round_d = round_q;
        done    = 1'b0;
        case (state_q)
            KS_IDLE: begin
                if (start) begin
                    key_d   = key;
                    round_d = 4'd0;
                    state_d = KS_EMIT;
                end
            end
            KS_EMIT: begin
                if (rk_ready) begin
                    if (round_q == AES_ROUNDS) begin
                        done    = 1'b1;
                        state_d = KS_IDLE;
                    end else begin
                        key_d   = key_exp;
                        round_d = round_q + 4'd1;
                    end
                end
            end
            default: state_d = KS_IDLE;
        endcase
    end

    assign busy     = (state_q == KS_EMIT);
    assign rk_valid = (state_q == KS_EMIT);
    assign rk_data  = cur_key;
    assign rk_round = round_q;

`ifdef AES_KS_RK_STORE_EN
    key128_t store [0:10];

    // Contents need no reset; keys_valid gates their meaning.
    always_ff @(posedge clk) begin
        if (rk_valid && rk_ready) begin
            store[round_q] <= cur_key;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            keys_valid <= 1'b0;
            rd_data    <= '0;
        end else begin
            if (state_q == KS_IDLE && start) begin
                keys_valid <= 1'b0;
            end else if (done) begin
                keys_valid <= 1'b1;
            end
            rd_data <= (rd_idx <= AES_ROUNDS) ? store[rd_idx] : '0;
        end
    end
`endif

endmodule

// File: tb/tb_aes_key_sched.sv
// Directed bench for aes_key_sched against FIPS-197 key-expansion vectors.
module tb_aes_key_sched;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [127:0] key = '0;
    logic         busy;
    logic         rk_valid;
    logic         rk_ready = 1'b1;
    logic [127:0] rk_data;
    logic [3:0]   rk_round;
    logic         done;
`ifdef AES_KS_RK_STORE_EN
    logic [3:0]   rd_idx = '0;
    logic [127:0] rd_data;
    logic         keys_valid;
`endif

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] ALT_KEY  = 128'hffeeddccbbaa99887766554433221100;

    logic [127:0] rk_exp [0:10];

    always #5 clk = ~clk;

    aes_key_sched dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .key        (key),
        .busy       (busy),
        .rk_valid   (rk_valid),
        .rk_ready   (rk_ready),
        .rk_data    (rk_data),
        .rk_round   (rk_round),
`ifdef AES_KS_RK_STORE_EN
        .rd_idx     (rd_idx),
        .rd_data    (rd_data),
        .keys_valid (keys_valid),
`endif
        .done       (done)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drives start for one cycle; returns at the negedge after acceptance (rk0 visible).
    task automatic do_start(input logic [127:0] k);
        start = 1'b1;
        key   = k;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Full-rate run; spurious starts are pulsed mid-expansion when mid_starts is set.
    task automatic run_full_rate(input bit mid_starts);
        rk_ready = 1'b1;
        do_start(FIPS_KEY);
        for (int r = 0; r <= 10; r++) begin
            check($sformatf("valid_r%0d", r), {127'd0, rk_valid}, 128'd1);
            check($sformatf("busy_r%0d", r), {127'd0, busy}, 128'd1);
            check($sformatf("round_r%0d", r), {124'd0, rk_round}, r);
            check($sformatf("data_r%0d", r), rk_data, rk_exp[r]);
            check($sformatf("done_r%0d", r), {127'd0, done}, (r == 10) ? 128'd1 : 128'd0);
            if (mid_starts && (r == 2 || r == 6)) begin
                start = 1'b1;
                key   = ALT_KEY;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("busy_after", {127'd0, busy}, 128'd0);
        check("valid_after", {127'd0, rk_valid}, 128'd0);
    endtask

    initial begin
        int exp_idx;
        int budget;
        bit xfer;

        rk_exp[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        rk_exp[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        rk_exp[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        rk_exp[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        rk_exp[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        rk_exp[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        rk_exp[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        rk_exp[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        rk_exp[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        rk_exp[9]  = 128'hac7766f319fadc2128d12941575c006e;
        rk_exp[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        repeat (2) @(negedge clk);
        check("rst_busy", {127'd0, busy}, 128'd0);
        check("rst_valid", {127'd0, rk_valid}, 128'd0);
        check("rst_done", {127'd0, done}, 128'd0);
        check("rst_data", rk_data, 128'd0);
        check("rst_round", {124'd0, rk_round}, 128'd0);
`ifdef AES_KS_RK_STORE_EN
        check("rst_keys_valid", {127'd0, keys_valid}, 128'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        run_full_rate(1'b0);

`ifdef AES_KS_RK_STORE_EN
        check("store_keys_valid", {127'd0, keys_valid}, 128'd1);
        rd_idx = 4'd1;
        @(negedge clk);
        check("store_rd1", rd_data, rk_exp[1]);
        rd_idx = 4'd10;
        @(negedge clk);
        check("store_rd10", rd_data, rk_exp[10]);
        rd_idx = 4'd15;
        @(negedge clk);
        check("store_rd15", rd_data, 128'd0);
        rd_idx = 4'd0;
`endif

        run_full_rate(1'b1);

`ifdef AES_KS_RK_STORE_EN
        check("store_kv_before", {127'd0, keys_valid}, 128'd1);
        do_start(ALT_KEY);
        check("store_kv_cleared", {127'd0, keys_valid}, 128'd0);
        repeat (11) @(negedge clk);
        check("alt_idle", {127'd0, busy}, 128'd0);
`endif

        // Backpressure: pseudo-random ready; values must hold through stalls.
        do_start(FIPS_KEY);
        exp_idx = 0;
        budget  = 300;
        while (exp_idx <= 10 && budget > 0) begin
            check("bp_valid", {127'd0, rk_valid}, 128'd1);
            check($sformatf("bp_round_%0d", exp_idx), {124'd0, rk_round}, exp_idx);
            check($sformatf("bp_data_%0d", exp_idx), rk_data, rk_exp[exp_idx]);
            rk_ready = ($urandom_range(0, 2) != 0);
            #1;
            xfer = rk_ready;
            check("bp_done", {127'd0, done}, (xfer && exp_idx == 10) ? 128'd1 : 128'd0);
            if (xfer) exp_idx++;
            budget--;
            @(negedge clk);
        end
        if (budget == 0) check("bp_timeout", 128'd0, 128'd1);
        rk_ready = 1'b1;
        check("bp_idle", {127'd0, rk_valid}, 128'd0);

        // Back-to-back: restart in the cycle busy falls.
        do_start(ALT_KEY);
        repeat (10) @(negedge clk);
        check("b2b_done", {127'd0, done}, 128'd1);
        @(negedge clk);
        check("b2b_busy_low", {127'd0, busy}, 128'd0);
        do_start(FIPS_KEY);
        check("b2b_rk0", rk_data, FIPS_KEY);
        check("b2b_round0", {124'd0, rk_round}, 128'd0);
        check("b2b_valid", {127'd0, rk_valid}, 128'd1);

        // Asynchronous reset mid-expansion.
        repeat (4) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", {127'd0, busy}, 128'd0);
        check("arst_valid", {127'd0, rk_valid}, 128'd0);
        check("arst_data", rk_data, 128'd0);
        check("arst_round", {124'd0, rk_round}, 128'd0);
        check("arst_done", {127'd0, done}, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("arst_quiet", {127'd0, rk_valid}, 128'd0);
        do_start(128'd0);
        check("zero_rk0", rk_data, 128'd0);
        @(negedge clk);
        check("zero_rk1", rk_data, 128'h62636363626363636263636362636363);
        check("zero_round1", {124'd0, rk_round}, 128'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
